// File: rtl/pipe_buf.sv
// pipe_buf: circular-buffer pipeline FIFO with registered valid/ready.
// Optional macro PIPE_BUF_DATA_GATE_EN zeroes pout_data while empty.
module pipe_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic                    pin_valid,
  input  logic [DATA_WIDTH-1:0]   pin_data,
  output logic                    pin_ready,
  output logic                    pout_valid,
  output logic [DATA_WIDTH-1:0]   pout_data,
  input  logic                    pout_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // ready/valid come only from cnt, so no comb path from pout_ready
  assign pin_ready  = (cnt != FULL);
  assign pout_valid = (cnt != '0);
  assign push       = pin_valid & pin_ready;
  assign pop        = pout_valid & pout_ready;
  assign count      = cnt;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= pin_data;
  end

`ifdef PIPE_BUF_DATA_GATE_EN
  assign pout_data = pout_valid ? head : '0;
`else
  assign pout_data = head;
`endif

endmodule

// File: tb/tb_pipe_buf.sv
// tb_pipe_buf: vector table plus queue-model random checks
// across DEPTH=4, DEPTH=2 and DEPTH=8 instances.
module tb_pipe_buf;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DEPTH=4 instance
  logic          f4 = 0, pv4 = 0, pr4 = 0, rdy4, vld4;
  logic [DW-1:0] pd4 = 0, po4;
  logic [2:0]    c4;
  pipe_buf #(.DATA_WIDTH(DW), .DEPTH(4)) u4 (
    .clk(clk), .rstn(rstn), .flush(f4),
    .pin_valid(pv4), .pin_data(pd4), .pin_ready(rdy4),
    .pout_valid(vld4), .pout_data(po4), .pout_ready(pr4),
    .count(c4));

  // DEPTH=2 instance
  logic          f2 = 0, pv2 = 0, pr2 = 0, rdy2, vld2;
  logic [DW-1:0] pd2 = 0, po2;
  logic [1:0]    c2;
  pipe_buf #(.DATA_WIDTH(DW), .DEPTH(2)) u2 (
    .clk(clk), .rstn(rstn), .flush(f2),
    .pin_valid(pv2), .pin_data(pd2), .pin_ready(rdy2),
    .pout_valid(vld2), .pout_data(po2), .pout_ready(pr2),
    .count(c2));

  // DEPTH=8 instance
  logic          f8 = 0, pv8 = 0, pr8 = 0, rdy8, vld8;
  logic [DW-1:0] pd8 = 0, po8;
  logic [3:0]    c8;
  pipe_buf #(.DATA_WIDTH(DW), .DEPTH(8)) u8 (
    .clk(clk), .rstn(rstn), .flush(f8),
    .pin_valid(pv8), .pin_data(pd8), .pin_ready(rdy8),
    .pout_valid(vld8), .pout_data(po8), .pout_ready(pr8),
    .count(c8));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          fl;
    logic          pv;
    logic [DW-1:0] pd;
    logic          pr;
    logic          e_rdy;
    logic          e_vld;
    int            e_cnt;
    logic [DW-1:0] e_dat;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic fl, logic pv, int pd, logic pr,
                              logic er, logic ev, int ec, int ed);
    vec_t v;
    v.fl = fl; v.pv = pv; v.pd = DW'(pd); v.pr = pr;
    v.e_rdy = er; v.e_vld = ev; v.e_cnt = ec; v.e_dat = DW'(ed);
    return v;
  endfunction

  initial begin
    logic [DW-1:0] q[$];
    int outs, pushes, wraps;
    logic [DW-1:0] nxt;
    bit dpush, dpop;

    // reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    check("rst_rdy", rdy4, 1);
    check("rst_vld", vld4, 0);
    check("rst_cnt", c4, 0);
    check("rst_cnt2", c2, 0);
    check("rst_cnt8", c8, 0);
`ifdef PIPE_BUF_DATA_GATE_EN
    check("rst_dat", po4, 0);
`endif

    // fill, refuse, drain, full-with-pop, flush collision
    vt.push_back(mk(0, 1, 'hA0, 0, 1, 1, 1, 'hA0));
    vt.push_back(mk(0, 1, 'hA1, 0, 1, 1, 2, 'hA0));
    vt.push_back(mk(0, 1, 'hA2, 0, 1, 1, 3, 'hA0));
    vt.push_back(mk(0, 1, 'hA3, 0, 0, 1, 4, 'hA0));
    vt.push_back(mk(0, 1, 'hA4, 0, 0, 1, 4, 'hA0));
    vt.push_back(mk(0, 0, 'hA4, 1, 1, 1, 3, 'hA1));
    vt.push_back(mk(0, 0, 'hA4, 1, 1, 1, 2, 'hA2));
    vt.push_back(mk(0, 0, 'hA4, 1, 1, 1, 1, 'hA3));
    vt.push_back(mk(0, 0, 'hA4, 1, 1, 0, 0, 0));
    vt.push_back(mk(0, 1, 'hB0, 0, 1, 1, 1, 'hB0));
    vt.push_back(mk(0, 1, 'hB1, 0, 1, 1, 2, 'hB0));
    vt.push_back(mk(0, 1, 'hB2, 0, 1, 1, 3, 'hB0));
    vt.push_back(mk(0, 1, 'hB3, 0, 0, 1, 4, 'hB0));
    vt.push_back(mk(0, 1, 'hB4, 1, 1, 1, 3, 'hB1));
    vt.push_back(mk(0, 1, 'hB4, 0, 0, 1, 4, 'hB1));
    vt.push_back(mk(0, 0, 'hB5, 1, 1, 1, 3, 'hB2));
    vt.push_back(mk(1, 1, 'hB5, 1, 1, 0, 0, 0));
    vt.push_back(mk(0, 1, 'hC0, 0, 1, 1, 1, 'hC0));
    vt.push_back(mk(0, 0, 'hC1, 1, 1, 0, 0, 0));

    foreach (vt[i]) begin
      @(negedge clk);
      f4 = vt[i].fl; pv4 = vt[i].pv;
      pd4 = vt[i].pd; pr4 = vt[i].pr;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rdy", i), rdy4, vt[i].e_rdy);
      check($sformatf("v%0d_vld", i), vld4, vt[i].e_vld);
      check($sformatf("v%0d_cnt", i), c4, vt[i].e_cnt);
      if (vt[i].e_vld)
        check($sformatf("v%0d_dat", i), po4, vt[i].e_dat);
    end

    // reset mid-transfer, then a fresh push
    @(negedge clk);
    f4 = 0; pv4 = 1; pd4 = 'hD7; pr4 = 0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mrst_cnt", c4, 0);
    check("mrst_rdy", rdy4, 1);
    check("mrst_vld", vld4, 0);
    pv4 = 0;
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    pv4 = 1; pd4 = 'hD0;
    @(posedge clk);
    #1;
    check("mrst_cnt1", c4, 1);
    check("mrst_head", po4, 'hD0);
    @(negedge clk) pv4 = 0;

    // streaming at DEPTH=2
    q.delete();
    outs = 0;
    nxt = 0;
    pv2 = 1; pr2 = 1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      pd2 = nxt;
      check("st_cnt", c2, q.size());
      check("st_vld", vld2, int'(q.size() != 0));
      check("st_rdy", rdy2, int'(q.size() < 2));
      if (cyc > 1 && c2 > 1) check("st_cnt_le1", c2, 1);
      dpush = q.size() < 2;
      dpop  = q.size() > 0;
      if (dpop) begin
        check("st_dat", po2, q[0]);
        void'(q.pop_front());
        outs++;
      end
      if (dpush) begin
        q.push_back(nxt);
        nxt++;
      end
      @(negedge clk);
    end
    pv2 = 0; pr2 = 0;
    total++;
    if (outs < 99) begin
      bad++;
      $display("FAIL st_outs: got %0d expected >=99", outs);
    end

    // random wrap and backpressure at DEPTH=8
    q.delete();
    pushes = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check("rn_cnt", c8, q.size());
      check("rn_vld", vld8, int'(q.size() != 0));
      check("rn_rdy", rdy8, int'(q.size() < 8));
      if (q.size() != 0) check("rn_dat", po8, q[0]);
      pv8 = 1'($urandom);
      pr8 = 1'($urandom);
      pd8 = DW'($urandom);
      dpush = pv8 && q.size() < 8;
      dpop  = pr8 && q.size() > 0;
      if (dpop) void'(q.pop_front());
      if (dpush) begin
        q.push_back(pd8);
        pushes++;
      end
      @(negedge clk);
    end
    pv8 = 0; pr8 = 0;
    wraps = pushes / 8;
    total++;
    if (wraps < 100) begin
      bad++;
      $display("FAIL rn_wraps: got %0d expected >=100", wraps);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
